// File: rtl/melody_sequencer_pkg.sv
// melody_sequencer_pkg: note codes, ROM field widths and FSM state type
package melody_sequencer_pkg;
   localparam int NOTE_W = 4;
   localparam int UNITS_W = 3;
   localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd0;
   localparam logic [NOTE_W-1:0] NOTE_C4 = 4'd1;
   localparam logic [NOTE_W-1:0] NOTE_D = 4'd2;
   localparam logic [NOTE_W-1:0] NOTE_E = 4'd3;
   localparam logic [NOTE_W-1:0] NOTE_F = 4'd4;
   localparam logic [NOTE_W-1:0] NOTE_G = 4'd5;
   localparam logic [NOTE_W-1:0] NOTE_A = 4'd6;
   localparam logic [NOTE_W-1:0] NOTE_B = 4'd7;
   localparam logic [NOTE_W-1:0] NOTE_C5 = 4'd8;
   localparam logic [3:0] LAST_IDX = 4'd14;
   typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;
endpackage

// File: rtl/melody_sequencer_if.sv
// melody_sequencer_if: control, keyboard and tone-generator signals of the melody player
interface melody_sequencer_if;
   import melody_sequencer_pkg::*;
   logic play;
   logic stop;
   logic [NOTE_W-1:0] key_note;
   logic [NOTE_W-1:0] note_out;
   logic busy;
   logic [3:0] idx;
   logic done;
   modport master (output play, stop, key_note, input note_out, busy, idx, done);
   modport slave (input play, stop, key_note, output note_out, busy, idx, done);
endinterface

// File: rtl/melody_sequencer_rom.sv
// melody_rom: Ode to Joy opening phrase as {note, units} entries
module melody_rom
   import melody_sequencer_pkg::*;
(
   input  logic [3:0]         idx,
   output logic [NOTE_W-1:0]  note,
   output logic [UNITS_W-1:0] units
);
   always_comb begin
      case (idx)
         4'd0, 4'd1, 4'd6, 4'd11: {note, units} = {NOTE_E, 3'd2};
         4'd2, 4'd5:              {note, units} = {NOTE_F, 3'd2};
         4'd3, 4'd4:              {note, units} = {NOTE_G, 3'd2};
         4'd7, 4'd10:             {note, units} = {NOTE_D, 3'd2};
         4'd8, 4'd9:              {note, units} = {NOTE_C4, 3'd2};
         4'd12:                   {note, units} = {NOTE_E, 3'd3};
         4'd13:                   {note, units} = {NOTE_D, 3'd1};
         4'd14:                   {note, units} = {NOTE_D, 3'd4};
         default:                 {note, units} = {NOTE_NONE, 3'd1};
      endcase
   end
endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: autoplays the melody ROM with timed notes and gaps,
// otherwise passes the live keyboard note through to the tone generator.
module melody_sequencer
   import melody_sequencer_pkg::*;
#(
   parameter int UNIT_CYCLES = 12_500_000,
   parameter int GAP_CYCLES = 1_000_000,
   parameter int CNT_W = 27,
   parameter bit LOOP = 1'b0
) (
   input logic CLK,
   input logic RESET,
   melody_sequencer_if.slave bus
);
   state_t state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, note_len;
   logic [3:0] idx, idx_n;
   logic [NOTE_W-1:0] note_out, note_n, rom_note;
   logic [UNITS_W-1:0] rom_units;
   logic done, done_n, abort, expire;
   // ROM is addressed by the next index so a new note's code and length load together
   melody_rom u_rom (.idx(idx_n), .note(rom_note), .units(rom_units));
   assign note_len = {{(CNT_W-UNITS_W){1'b0}}, rom_units} * CNT_W'(UNIT_CYCLES) - CNT_W'(1);
   assign abort = bus.stop || bus.key_note != NOTE_NONE;
   assign expire = cnt == '0;
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= S_IDLE;
         cnt <= '0;
         idx <= '0;
         note_out <= NOTE_NONE;
         done <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         idx <= idx_n;
         note_out <= note_n;
         done <= done_n;
      end
   end
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      idx_n = idx;
      note_n = note_out;
      done_n = 1'b0;
      case (state)
         S_IDLE: begin
            note_n = bus.key_note;
            if (bus.play && !bus.stop) begin
               state_n = S_NOTE;
               idx_n = '0;
               note_n = rom_note;
               cnt_n = note_len;
            end
         end
         S_NOTE: begin
            if (abort) begin
               state_n = S_IDLE;
               idx_n = '0;
               note_n = bus.key_note;
            end else if (expire) begin
               state_n = S_GAP;
               cnt_n = CNT_W'(GAP_CYCLES - 1);
               note_n = NOTE_NONE;
            end else cnt_n = cnt - CNT_W'(1);
         end
         default: begin
            if (abort) begin
               state_n = S_IDLE;
               idx_n = '0;
               note_n = bus.key_note;
            end else if (expire) begin
               done_n = idx >= LAST_IDX;
               idx_n = idx < LAST_IDX ? idx + 4'd1 : 4'd0;
               state_n = (idx < LAST_IDX || LOOP) ? S_NOTE : S_IDLE;
               note_n = (idx < LAST_IDX || LOOP) ? rom_note : bus.key_note;
               cnt_n = note_len;
            end else cnt_n = cnt - CNT_W'(1);
         end
      endcase
   end
   assign bus.note_out = note_out;
   assign bus.busy = state != S_IDLE;
   assign bus.idx = idx;
   assign bus.done = done;
endmodule
